car_sensor_emulator: RTL and testbench
======================================

// Module: car_sensor_emulator
// PURPOSE
//   Drives the two parking-lot photo-sensor lines {a,b} the way a passing car does: the
//   transmit side of the gate sensor interface feeding the entry/exit detector FSM.
//   Accepts an enter/exit request and plays the 4-phase ab sequence with a programmable
//   per-phase dwell, then reports completion. Used as bench stimulus and for gate self-test.
// PARAMETERS
//   DWELL_W  8  width of dwell input / phase counter (max dwell 2^DWELL_W-1 cycles)
// PORTS
//   clk      in   1        system clock, all logic on rising edge
//   reset    in   1        asynchronous, active-high reset
//   start    in   1        request a car pass; accepted only when busy=0
//   dir      in   1        0=enter, 1=exit; sampled with accepted start
//   dwell    in   DWELL_W  cycles per phase; sampled with accepted start; 0 treated as 1
//   ab       out  2        {a,b} sensor lines, registered
//   busy     out  1        sequence in progress (registered)
//   done     out  1        1-cycle pulse: sequence completed
//   abort    in   1        [PL_ABORT_EN only] car backs out
//   aborted  out  1        [PL_ABORT_EN only] 1-cycle pulse: back-out completed
// BEHAVIOUR
//   Reset (async): state=IDLE, ab=00, busy=0, done=0, aborted=0, counter=0, latched dir/dwell=0.
//   States: IDLE, P1, P2, P3, FIN (+ R2, R1, RFIN with PL_ABORT_EN).
//   Phase ab: enter P1=10 P2=11 P3=01; exit P1=01 P2=11 P3=10; IDLE/FIN/RFIN ab=00.
//   IDLE: start=1 at edge -> P1; latch dir, D=max(dwell,1); counter loads D-1.
//   Px: held exactly D cycles; counter decrements each cycle; at counter==0 advance
//     P1->P2->P3->FIN, reloading D-1. FIN: ab=00, done=1 for exactly 1 cycle, then IDLE.
//   busy=1 from cycle after start acceptance through FIN inclusive: 3D+1 cycles total.
//   start while busy=1 (incl. FIN cycle): ignored, no queueing. dir/dwell changes mid-run ignored.
//   Back-to-back: start held high re-accepts in first IDLE cycle after FIN (1 idle cycle min).
//   Counter width DWELL_W; no wrap possible since load <= 2^DWELL_W-2.
//   All outputs registered; no combinational path input->output.
//   Reset mid-sequence: ab forced 00 immediately, no done/aborted pulse.
// CONFIGURATION
//   PL_ABORT_EN defined: abort port and aborted port exist. abort=1 sampled in P1/P2/P3
//     reverses the car: P1->RFIN; P2->R1; P3->R2->R1->RFIN. R2 ab=P2 value, R1 ab=P1 value,
//     each held D cycles (counter reloads D-1 on abort). RFIN: ab=00, aborted=1 one cycle,
//     done stays 0, then IDLE. abort ignored in IDLE/FIN/R*/RFIN. abort and counter==0 in
//     same cycle: abort wins. Detector sees no complete pass -> no y/z.
//   PL_ABORT_EN undefined: no abort/aborted ports, no R states; sequence always completes.
// TESTING
//   1 enter, dwell=2: start@t0 -> ab t1..t7 = 10,10,11,11,01,01,00; done=1 only t7; busy t1..t7.
//   2 exit, dwell=1: ab = 01,11,10,00; done on 4th cycle; detector-side z pulses, y stays 0.
//   3 dwell=0: identical to dwell=1 trace; dwell=255: each phase exactly 255 cycles.
//   4 start pulsed at t3 of test 1 and held through FIN: t3 ignored; new start accepted t8.
//   5 reset asserted mid-P2 (between edges): ab=00, busy=0 same instant; restarts cleanly.
//   6 PL_ABORT_EN, enter dwell=1, abort in P3: ab = 10,11,01,11,10,00; aborted=1 last, done=0.

Source files
------------

// File: rtl/car_sensor_if.sv
// rtl/car_sensor_if.sv - request/status bundle between a car-pass requester and the sensor emulator
// Signals: start/dir/dwell request a pass; ab/busy/done report sensor lines and progress.
// Macro PL_ABORT_EN adds abort (request back-out) and aborted (back-out finished).
// Modports: master = requester side, slave = emulator side.
interface car_sensor_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         ab;
    logic               busy;
    logic               done;
`ifdef PL_ABORT_EN
    logic               abort;
    logic               aborted;

    modport master (output start, dir, dwell, abort, input ab, busy, done, aborted);
    modport slave  (input start, dir, dwell, abort, output ab, busy, done, aborted);
`else
    modport master (output start, dir, dwell, input ab, busy, done);
    modport slave  (input start, dir, dwell, output ab, busy, done);
`endif
endinterface

// File: rtl/car_sensor_emulator.sv
// rtl/car_sensor_emulator.sv - plays the 4-phase {a,b} photo-sensor sequence of a passing car
// Ports: clk, reset (async, active-high), bus (car_sensor_if.slave):
//   start/dir/dwell in, ab/busy/done out (all outputs registered).
// Macro PL_ABORT_EN: enables abort in / aborted out and the reverse (back-out) states.
// Each phase is held D = max(dwell,1) cycles; FIN shows ab=00 with a one-cycle done.
module car_sensor_emulator #(
    parameter int DWELL_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    car_sensor_if.slave    bus
);

`ifdef PL_ABORT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_P1, S_P2, S_P3, S_FIN, S_R2, S_R1, S_RFIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_P1, S_P2, S_P3, S_FIN
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dir_q, dir_d;
    logic [1:0]         ab_q, ab_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef PL_ABORT_EN
    logic               aborted_q, aborted_d;
`endif
    logic [DWELL_W-1:0] dwell_eff;

    // A dwell of zero would make phases vanish; treat it as one cycle.
    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_P1;
                    dir_d   = bus.dir;
                    dwell_d = dwell_eff;
                    cnt_d   = dwell_eff - DWELL_W'(1);
                end
            end
            S_P1, S_P2, S_P3: begin
`ifdef PL_ABORT_EN
                // Back-out takes priority over a phase that is just expiring.
                if (bus.abort) begin
                    cnt_d = dwell_q - DWELL_W'(1);
                    case (state_q)
                        S_P1:    state_d = S_RFIN;
                        S_P2:    state_d = S_R1;
                        default: state_d = S_R2;
                    endcase
                end else
`endif
                if (cnt_q == '0) begin
                    cnt_d = dwell_q - DWELL_W'(1);
                    case (state_q)
                        S_P1:    state_d = S_P2;
                        S_P2:    state_d = S_P3;
                        default: state_d = S_FIN;
                    endcase
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
`ifdef PL_ABORT_EN
            S_R2, S_R1: begin
                if (cnt_q == '0) begin
                    cnt_d   = dwell_q - DWELL_W'(1);
                    state_d = (state_q == S_R2) ? S_R1 : S_RFIN;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            S_RFIN:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        ab_d   = 2'b00;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
`ifdef PL_ABORT_EN
        aborted_d = (state_d == S_RFIN);
`endif
        case (state_d)
            S_P1:    ab_d = dir_d ? 2'b01 : 2'b10;
            S_P2:    ab_d = 2'b11;
            S_P3:    ab_d = dir_d ? 2'b10 : 2'b01;
`ifdef PL_ABORT_EN
            S_R2:    ab_d = 2'b11;
            S_R1:    ab_d = dir_d ? 2'b01 : 2'b10;
`endif
            default: ab_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dwell_q   <= '0;
            dir_q     <= 1'b0;
            ab_q      <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dwell_q   <= dwell_d;
            dir_q     <= dir_d;
            ab_q      <= ab_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PL_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign bus.ab   = ab_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef PL_ABORT_EN
    assign bus.aborted = aborted_q;
`endif

endmodule

// File: tb/tb_car_sensor_emulator.sv
// tb/tb_car_sensor_emulator.sv - randomized self-checking bench for car_sensor_emulator
module tb_car_sensor_emulator;
    localparam int DWELL_W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    car_sensor_if #(.DWELL_W(DWELL_W)) bus ();

    car_sensor_emulator #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected per-cycle entries {ab[1:0], busy, done, aborted}.
    logic [4:0] exp_q[$];
    logic [1:0] tbl [2][3] = '{'{2'b10, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b10}};

    function automatic logic [4:0] obs();
`ifdef PL_ABORT_EN
        return {bus.ab, bus.busy, bus.done, bus.aborted};
`else
        return {bus.ab, bus.busy, bus.done, 1'b0};
`endif
    endfunction

    function automatic int eff(input int dw);
        return (dw == 0) ? 1 : dw;
    endfunction

    // Full pass: three phases of D cycles, FIN cycle, then one idle cycle.
    function automatic void build_pass(input bit d, input int dw);
        exp_q.delete();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < eff(dw); k++) exp_q.push_back({tbl[d][p], 3'b100});
        exp_q.push_back(5'b00110);
        exp_q.push_back(5'b00000);
    endfunction

    // Abort sampled in the first cycle of phase p: retrace the earlier phases backwards.
    function automatic void build_abort(input bit d, input int dw, input int p);
        exp_q.delete();
        for (int q = 0; q < p; q++)
            for (int k = 0; k < eff(dw); k++) exp_q.push_back({tbl[d][q], 3'b100});
        exp_q.push_back({tbl[d][p], 3'b100});
        for (int q = p - 1; q >= 0; q--)
            for (int k = 0; k < eff(dw); k++) exp_q.push_back({tbl[d][q], 3'b100});
        exp_q.push_back(5'b00101);
        exp_q.push_back(5'b00000);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 5'b0) $display("FAIL reset_async got %b want 00000", obs());
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs() !== 5'b0) $display("FAIL reset_idle got %b want 00000", obs());
        else passed++;
    endtask

    task automatic test_enter();
        bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        build_pass(1'b0, 2);
        foreach (exp_q[i]) begin
            bus.dir = 1'($urandom); bus.dwell = 8'($urandom);
            checks++;
            if (obs() !== exp_q[i]) $display("FAIL enter c%0d got %b want %b", i, obs(), exp_q[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exit();
        bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        build_pass(1'b1, 1);
        foreach (exp_q[i]) begin
            checks++;
            if (obs() !== exp_q[i]) $display("FAIL exit c%0d got %b want %b", i, obs(), exp_q[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dwell_bounds();
        int dws[2] = '{0, 255};
        foreach (dws[j]) begin
            bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 8'(dws[j]);
            @(posedge clk); #1;
            bus.start = 1'b0;
            build_pass(1'b0, dws[j]);
            foreach (exp_q[i]) begin
                checks++;
                if (obs() !== exp_q[i])
                    $display("FAIL dwell%0d c%0d got %b want %b", dws[j], i, obs(), exp_q[i]);
                else passed++;
                @(posedge clk); #1;
            end
        end
    endtask

    // Random passes; dir/dwell/start are scrambled while busy and must be ignored.
    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            bit d  = 1'($urandom);
            int dw = int'($urandom_range(0, 5));
            bus.start = 1'b1; bus.dir = d; bus.dwell = 8'(dw);
            @(posedge clk); #1;
            build_pass(d, dw);
            foreach (exp_q[i]) begin
                bus.dir = 1'($urandom); bus.dwell = 8'($urandom);
                bus.start = exp_q[i][2] ? 1'($urandom) : 1'b0;
                checks++;
                if (obs() !== exp_q[i])
                    $display("FAIL random r%0d c%0d got %b want %b", r, i, obs(), exp_q[i]);
                else passed++;
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
        end
    endtask

    // start held high throughout: re-accepted in the single idle cycle after FIN.
    task automatic test_back_to_back();
        bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 8'd2;
        @(posedge clk); #1;
        for (int run = 0; run < 2; run++) begin
            build_pass(1'b0, 2);
            if (run == 1) bus.start = 1'b0;
            foreach (exp_q[i]) begin
                checks++;
                if (obs() !== exp_q[i])
                    $display("FAIL b2b run%0d c%0d got %b want %b", run, i, obs(), exp_q[i]);
                else passed++;
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (obs() !== 5'b11100) $display("FAIL mid_p2 got %b want 11100", obs());
        else passed++;
        #3 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 5'b0) $display("FAIL reset_mid got %b want 00000", obs());
        else passed++;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs() !== 5'b0) $display("FAIL reset_mid_idle got %b want 00000", obs());
        else passed++;
        bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        build_pass(1'b1, 2);
        foreach (exp_q[i]) begin
            checks++;
            if (obs() !== exp_q[i]) $display("FAIL restart c%0d got %b want %b", i, obs(), exp_q[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

`ifdef PL_ABORT_EN
    task automatic test_abort();
        int cases[4][3] = '{'{0, 1, 2}, '{0, 2, 0}, '{1, 2, 1}, '{1, 3, 2}};
        foreach (cases[j]) begin
            bit d  = 1'(cases[j][0]);
            int dw = cases[j][1];
            int p  = cases[j][2];
            bus.start = 1'b1; bus.dir = d; bus.dwell = 8'(dw);
            @(posedge clk); #1;
            bus.start = 1'b0;
            build_abort(d, dw, p);
            foreach (exp_q[i]) begin
                bus.abort = (i == p * eff(dw));
                checks++;
                if (obs() !== exp_q[i])
                    $display("FAIL abort k%0d c%0d got %b want %b", j, i, obs(), exp_q[i]);
                else passed++;
                @(posedge clk); #1;
            end
            bus.abort = 1'b0;
        end
    endtask
`endif

    initial begin
        clk = 1'b0;
        checks = 0;
        passed = 0;
        bus.start = 1'b0;
        bus.dir = 1'b0;
        bus.dwell = '0;
`ifdef PL_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_enter();
        test_exit();
        test_dwell_bounds();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef PL_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
